// File: rtl/counter_pkg.sv
// Shared definitions for the counter checker.
//   chk_state_t      : checker state (IDLE -> SYNC -> LOCKED)
//   CNT_WIDTH        : default width of the observed counter value
//   SYNC_LEN_DEFAULT : default number of correct increments needed to lock
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam int CNT_WIDTH        = 8;
  localparam int SYNC_LEN_DEFAULT = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one on each cycle where inc is high,
// sticks at all-ones and never wraps.
//   clock : rising-edge clock
//   reset : asynchronous active-low clear
//   inc   : increment request for this cycle
//   count : registered count value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: hold at all-ones once reached.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Passive scoreboard for a free-running counter. Predicts the next value of
// the observed bus from the previous sample (0 after a counter reset, +1
// otherwise), locks after SYNC_LEN correct increments, and reports mismatch
// and wrap pulses plus a saturating mismatch count.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset of the checker
//   value     : observed counter output
//   dut_reset : observed synchronous active-high reset of the counter
//   enable    : low freezes the checker (no sampling, pulses deassert)
//   locked    : high while in LOCKED
//   mismatch  : one-cycle pulse on a failed compare while LOCKED
//   wrap      : one-cycle pulse on an all-ones -> 0 rollover while LOCKED
//   expected  : prediction compared at the next enabled edge
//   err_count : saturating mismatch count
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int SYNC_LEN = SYNC_LEN_DEFAULT,
  parameter int ERR_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             dut_reset,
  input  logic             enable,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count
);

  chk_state_t       state, state_next;
  logic [3:0]       sync_cnt, sync_cnt_next;
  logic [WIDTH-1:0] prev_value, prev_value_next;
  logic             prev_rst, prev_rst_next;
  logic [WIDTH-1:0] expected_next;
  logic             locked_next, mismatch_next, wrap_next;
  logic             err_inc;
  logic [WIDTH-1:0] predict;
  logic             hit;
  logic [3:0]       sync_cnt_inc;

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sync_cnt   <= 4'd0;
      prev_value <= '0;
      prev_rst   <= 1'b0;
      expected   <= '0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_next;
      sync_cnt   <= sync_cnt_next;
      prev_value <= prev_value_next;
      prev_rst   <= prev_rst_next;
      expected   <= expected_next;
      locked     <= locked_next;
      mismatch   <= mismatch_next;
      wrap       <= wrap_next;
    end
  end

  // Next-state, prediction and pulse logic.
  always_comb begin
    state_next      = state;
    sync_cnt_next   = sync_cnt;
    prev_value_next = prev_value;
    prev_rst_next   = prev_rst;
    expected_next   = expected;
    locked_next     = locked;
    mismatch_next   = 1'b0;
    wrap_next       = 1'b0;
    err_inc         = 1'b0;

    // A sample taken while the counter is in reset means 0 comes next.
    predict      = dut_reset ? '0 : (value + WIDTH'(1));
    hit          = (value == expected);
    sync_cnt_inc = sync_cnt + 4'd1;

    if (enable) begin
      // The prediction is always re-seeded from the current sample: on a hit
      // it equals the old chain, on a miss it restarts from the bad value.
      prev_value_next = value;
      prev_rst_next   = dut_reset;
      expected_next   = predict;

      case (state)
        IDLE: begin
          state_next    = SYNC;
          sync_cnt_next = 4'd0;
          locked_next   = 1'b0;
        end
        SYNC: begin
          if (hit) begin
            if (sync_cnt_inc == 4'(SYNC_LEN)) begin
              state_next    = LOCKED;
              sync_cnt_next = 4'd0;
              locked_next   = 1'b1;
            end else begin
              sync_cnt_next = sync_cnt_inc;
            end
          end else begin
            sync_cnt_next = 4'd0;
          end
        end
        LOCKED: begin
          if (hit) begin
            // A zero following an all-ones sample taken outside counter
            // reset is a genuine rollover.
            if ((prev_value == '1) && (value == '0) && !prev_rst) begin
              wrap_next = 1'b1;
            end else begin
              wrap_next = 1'b0;
            end
          end else begin
            mismatch_next = 1'b1;
            err_inc       = 1'b1;
            state_next    = SYNC;
            sync_cnt_next = 4'd0;
            locked_next   = 1'b0;
          end
        end
        default: begin
          state_next    = IDLE;
          sync_cnt_next = 4'd0;
          locked_next   = 1'b0;
        end
      endcase
    end else begin
      // Frozen: registers hold, pulses already defaulted low.
      state_next = state;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (err_inc),
    .count(err_count)
  );

endmodule

// File: tb/tb_counter_checker.sv
module tb_counter_checker;

  logic        clock;
  logic        reset;
  logic [7:0]  value;
  logic        dut_reset;
  logic        enable;
  logic        locked, mismatch, wrap;
  logic [7:0]  expected;
  logic [15:0] err_count;
  logic        locked2, mismatch2, wrap2;
  logic [7:0]  expected2;
  logic [1:0]  err_count2;

  int passed = 0;
  int total  = 0;
  logic [7:0] cnt;

  counter_checker dut (
    .clock(clock), .reset(reset), .value(value), .dut_reset(dut_reset),
    .enable(enable), .locked(locked), .mismatch(mismatch), .wrap(wrap),
    .expected(expected), .err_count(err_count)
  );

  counter_checker #(.ERR_W(2)) dut2 (
    .clock(clock), .reset(reset), .value(value), .dut_reset(dut_reset),
    .enable(enable), .locked(locked2), .mismatch(mismatch2), .wrap(wrap2),
    .expected(expected2), .err_count(err_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  v;
    logic        r;
    logic        en;
    logic        lk;
    logic        mis;
    logic        wr;
    logic [7:0]  exp;
    logic [15:0] err;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, want);
  endtask

  // Drive one sample and advance to just after the rising edge.
  task automatic cyc(input logic [7:0] v, input logic r, input logic en);
    value = v; dut_reset = r; enable = en;
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc(tab[i].v, tab[i].r, tab[i].en);
      chk($sformatf("vec%0d_locked", i),   {31'd0, locked},   {31'd0, tab[i].lk});
      chk($sformatf("vec%0d_mismatch", i), {31'd0, mismatch}, {31'd0, tab[i].mis});
      chk($sformatf("vec%0d_wrap", i),     {31'd0, wrap},     {31'd0, tab[i].wr});
      chk($sformatf("vec%0d_expected", i), {24'd0, expected}, {24'd0, tab[i].exp});
      chk($sformatf("vec%0d_err", i),      {16'd0, err_count}, {16'd0, tab[i].err});
    end
  endtask

  // Free-running counter cycles; none of these may raise mismatch.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(cnt, 1'b0, 1'b1);
      chk("run_mismatch", {31'd0, mismatch}, 32'd0);
      cnt = cnt + 8'd1;
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; value = 8'h00; dut_reset = 1'b0;

    // Lock from counter start 0x00, five samples to lock.
    tab.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 16'd0});
    tab.push_back('{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 16'd0});
    tab.push_back('{8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 16'd0});
    tab.push_back('{8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 16'd0});
    tab.push_back('{8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 16'd0});
    tab.push_back('{8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h06, 16'd0});
    // Glitch 0x55 where 0x30 is expected, then recovery (index 6..).
    tab.push_back('{8'h2E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2F, 16'd0});
    tab.push_back('{8'h2F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h30, 16'd0});
    tab.push_back('{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h56, 16'd1});
    tab.push_back('{8'h31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h32, 16'd1});
    tab.push_back('{8'h32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 16'd1});
    tab.push_back('{8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h34, 16'd1});
    tab.push_back('{8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h35, 16'd1});
    tab.push_back('{8'h35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h36, 16'd1});
    tab.push_back('{8'h36, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h37, 16'd1});

    // Reset state.
    #12;
    chk("rst_locked",   {31'd0, locked},    32'd0);
    chk("rst_mismatch", {31'd0, mismatch},  32'd0);
    chk("rst_wrap",     {31'd0, wrap},      32'd0);
    chk("rst_expected", {24'd0, expected},  32'd0);
    chk("rst_err",      {16'd0, err_count}, 32'd0);
    reset = 1'b1;

    apply(0, 5);
    cnt = 8'h06;
    run(40);                       // 0x06..0x2D
    apply(6, 14);
    cnt = 8'h37;

    // Wrap: run up to 0xFD then step through the rollover.
    run(int'(8'hFD) - int'(cnt));
    cyc(8'hFD, 1'b0, 1'b1); chk("wrap_fd", {31'd0, wrap}, 32'd0);
    cyc(8'hFE, 1'b0, 1'b1); chk("wrap_fe", {31'd0, wrap}, 32'd0);
    cyc(8'hFF, 1'b0, 1'b1); chk("wrap_ff", {31'd0, wrap}, 32'd0);
    cyc(8'h00, 1'b0, 1'b1); chk("wrap_00", {31'd0, wrap}, 32'd1);
    chk("wrap_00_mis", {31'd0, mismatch}, 32'd0);
    chk("wrap_00_exp", {24'd0, expected}, 32'h01);
    cyc(8'h01, 1'b0, 1'b1); chk("wrap_01", {31'd0, wrap}, 32'd0);
    cyc(8'h02, 1'b0, 1'b1); chk("wrap_02", {31'd0, wrap}, 32'd0);
    chk("wrap_locked", {31'd0, locked}, 32'd1);
    chk("wrap_err", {16'd0, err_count}, 32'd1);

    // Enable low while the counter runs on; re-enable must flag a miss.
    for (int i = 3; i <= 5; i++) begin
      cyc(8'(i), 1'b0, 1'b0);
      chk("dis_expected", {24'd0, expected}, 32'h03);
      chk("dis_locked", {31'd0, locked}, 32'd1);
      chk("dis_mismatch", {31'd0, mismatch}, 32'd0);
    end
    cyc(8'h06, 1'b0, 1'b1);
    chk("reen_mismatch", {31'd0, mismatch}, 32'd1);
    chk("reen_err", {16'd0, err_count}, 32'd2);
    chk("reen_locked", {31'd0, locked}, 32'd0);
    chk("reen_expected", {24'd0, expected}, 32'h07);
    cyc(8'h07, 1'b0, 1'b1);
    chk("reen_pulse_end", {31'd0, mismatch}, 32'd0);
    cyc(8'h08, 1'b0, 1'b1);
    cyc(8'h09, 1'b0, 1'b1);
    cyc(8'h0A, 1'b0, 1'b1);
    chk("relock_locked", {31'd0, locked}, 32'd1);
    chk("relock_expected", {24'd0, expected}, 32'h0B);

    // Async reset between edges.
    #2 reset = 1'b0;
    #1;
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_err", {16'd0, err_count}, 32'd0);
    chk("arst_expected", {24'd0, expected}, 32'd0);
    chk("arst_err2", {30'd0, err_count2}, 32'd0);
    #2 reset = 1'b1;
    cyc(8'h10, 1'b0, 1'b1);
    chk("arst_seed_exp", {24'd0, expected}, 32'h11);
    chk("arst_seed_lk", {31'd0, locked}, 32'd0);
    cyc(8'h11, 1'b0, 1'b1);
    cyc(8'h12, 1'b0, 1'b1);
    cyc(8'h13, 1'b0, 1'b1);
    chk("arst_prelock", {31'd0, locked}, 32'd0);
    cyc(8'h14, 1'b0, 1'b1);
    chk("arst_relock", {31'd0, locked}, 32'd1);
    cnt = 8'h15;
    run(7);                        // 0x15..0x1B

    // Counter reset held 11 cycles starting at value 0x1C.
    cyc(8'h1C, 1'b1, 1'b1);
    chk("drst_first_lk", {31'd0, locked}, 32'd1);
    chk("drst_first_exp", {24'd0, expected}, 32'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(8'h00, 1'b1, 1'b1);
      chk("drst_lk", {31'd0, locked}, 32'd1);
      chk("drst_mis", {31'd0, mismatch}, 32'd0);
      chk("drst_wrap", {31'd0, wrap}, 32'd0);
      chk("drst_exp", {24'd0, expected}, 32'h00);
    end
    cyc(8'h00, 1'b0, 1'b1);
    chk("drst_rel_exp", {24'd0, expected}, 32'h01);
    chk("drst_rel_wrap", {31'd0, wrap}, 32'd0);
    cyc(8'h01, 1'b0, 1'b1);
    chk("drst_run_lk", {31'd0, locked}, 32'd1);
    chk("drst_err", {16'd0, err_count}, 32'd0);
    cnt = 8'h02;

    // Saturation: five glitches ten cycles apart.
    for (int g = 0; g < 5; g++) begin
      run(9);
      cyc(8'h55, 1'b0, 1'b1);
      chk("sat_pulse", {31'd0, mismatch}, 32'd1);
      cnt = cnt + 8'd1;
      if (g == 2) chk("sat_err2_at3", {30'd0, err_count2}, 32'd3);
      else if (g == 1) chk("sat_err2_at2", {30'd0, err_count2}, 32'd2);
    end
    chk("sat_err_main", {16'd0, err_count}, 32'd5);
    chk("sat_err2", {30'd0, err_count2}, 32'd3);
    run(5);
    chk("sat_relock2", {31'd0, locked2}, 32'd1);
    chk("sat_err2_hold", {30'd0, err_count2}, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
